// File: rtl/ppl_memory.sv
// MEM stage of a five-stage pipeline: EX/MEM register, word-addressed data
// memory with misalignment detection, and the MEM/WB register.
module ppl_memory #(
    parameter int ADDR_W = 6
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] exAlu,
    input  logic [31:0] exDataB,
    input  logic [4:0]  exReg,
    input  logic        exValid,
    input  logic        exWreg,
    input  logic        exM2reg,
    input  logic        exWmem,
    output logic [31:0] mmAlu,
    output logic [4:0]  mmReg,
    output logic        mmWreg,
    output logic        mmM2reg,
    output logic [31:0] wbData,
    output logic [4:0]  wbReg,
    output logic        wbWreg,
    output logic        memFault
);

    logic        em_valid;
    logic [31:0] em_alu;
    logic [31:0] em_data_b;
    logic [4:0]  em_reg;
    logic        em_wreg;
    logic        em_m2reg;
    logic        em_wmem;

    logic [31:0]       mem [2**ADDR_W];
    logic [ADDR_W-1:0] idx;
    logic [31:0]       rd_word;
    logic              misaligned;
    logic              mis_load;
    logic              do_write;

    // Upper address bits are ignored, so addresses alias every 2^(ADDR_W+2) bytes.
    assign idx        = em_alu[ADDR_W+1:2];
    assign rd_word    = mem[idx];
    assign misaligned = em_valid & (em_wmem | em_m2reg) & (em_alu[1:0] != 2'b00);
    assign mis_load   = misaligned & em_m2reg;
    assign do_write   = em_valid & em_wmem & ~misaligned & ~stall;

    assign mmAlu   = em_alu;
    assign mmReg   = em_reg;
    assign mmWreg  = em_valid & em_wreg;
    assign mmM2reg = em_valid & em_m2reg;

    // Flush wins over stall so a held slot can still be turned into a bubble.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            em_valid  <= 1'b0;
            em_alu    <= '0;
            em_data_b <= '0;
            em_reg    <= '0;
            em_wreg   <= 1'b0;
            em_m2reg  <= 1'b0;
            em_wmem   <= 1'b0;
        end else if (flush) begin
            em_valid <= 1'b0;
            em_wreg  <= 1'b0;
            em_m2reg <= 1'b0;
            em_wmem  <= 1'b0;
        end else if (!stall) begin
            em_valid  <= exValid;
            em_alu    <= exAlu;
            em_data_b <= exDataB;
            em_reg    <= exReg;
            em_wreg   <= exWreg;
            em_m2reg  <= exM2reg;
            em_wmem   <= exWmem;
        end
    end

    always_ff @(posedge clock) begin
        if (do_write) begin
            mem[idx] <= em_data_b;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wbData   <= '0;
            wbReg    <= '0;
            wbWreg   <= 1'b0;
            memFault <= 1'b0;
        end else if (!stall) begin
            if (em_m2reg) begin
                wbData <= mis_load ? 32'h0 : rd_word;
            end else begin
                wbData <= em_alu;
            end
            wbReg  <= em_reg;
            wbWreg <= em_valid & em_wreg & ~mis_load;
            if (misaligned) begin
                memFault <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ppl_memory.sv
// Directed bench for ppl_memory: transaction-level model checked every
// cycle, plus literal expectations for the key scenarios.
module tb_ppl_memory;

    localparam int AW = 6;

    logic        clock;
    logic        reset;
    logic        stall;
    logic        flush;
    logic [31:0] exAlu;
    logic [31:0] exDataB;
    logic [4:0]  exReg;
    logic        exValid;
    logic        exWreg;
    logic        exM2reg;
    logic        exWmem;
    logic [31:0] mmAlu;
    logic [4:0]  mmReg;
    logic        mmWreg;
    logic        mmM2reg;
    logic [31:0] wbData;
    logic [4:0]  wbReg;
    logic        wbWreg;
    logic        memFault;

    ppl_memory #(.ADDR_W(AW)) dut (
        .clock(clock), .reset(reset), .stall(stall), .flush(flush),
        .exAlu(exAlu), .exDataB(exDataB), .exReg(exReg),
        .exValid(exValid), .exWreg(exWreg), .exM2reg(exM2reg),
        .exWmem(exWmem),
        .mmAlu(mmAlu), .mmReg(mmReg), .mmWreg(mmWreg),
        .mmM2reg(mmM2reg),
        .wbData(wbData), .wbReg(wbReg), .wbWreg(wbWreg),
        .memFault(memFault)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int total;
    int passed;
    bit chk_en;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", name, act, exp);
        else
            passed++;
    endtask

    // Model: one in-flight instruction in MEM, one result in WB.
    typedef struct {
        bit        v;
        bit [31:0] alu;
        bit [31:0] db;
        bit [4:0]  r;
        bit        wr;
        bit        m2;
        bit        wm;
    } instr_t;

    instr_t    m_e;
    bit [31:0] m_wd;
    bit [4:0]  m_wr;
    bit        m_ww;
    bit        m_wv;
    bit        m_wk;
    bit        m_fault;
    bit [31:0] m_mem [2**AW];
    bit        m_known [2**AW];

    task automatic model_reset();
        m_e     = '{default: 0};
        m_wd    = 0;
        m_wr    = 0;
        m_ww    = 0;
        m_wv    = 0;
        m_wk    = 1;
        m_fault = 0;
    endtask

    task automatic model_edge();
        bit mis;
        int a;
        instr_t nxt;
        if (reset) begin
            model_reset();
            return;
        end
        nxt = '{v: exValid, alu: exAlu, db: exDataB, r: exReg,
                wr: exWreg, m2: exM2reg, wm: exWmem};
        if (!stall) begin
            a   = int'(m_e.alu[AW+1:2]);
            mis = m_e.v && (m_e.wm || m_e.m2) && (m_e.alu[1:0] != 0);
            if (m_e.m2) begin
                m_wd = mis ? 32'h0 : m_mem[a];
                m_wk = mis || m_known[a];
            end else begin
                m_wd = m_e.alu;
                m_wk = 1;
            end
            m_wr = m_e.r;
            m_wv = m_e.v;
            m_ww = m_e.v && m_e.wr && !(mis && m_e.m2);
            if (m_e.v && m_e.wm && !mis) begin
                m_mem[a]   = m_e.db;
                m_known[a] = 1;
            end
            if (mis) m_fault = 1;
        end
        if (flush) begin
            m_e.v  = 0;
            m_e.wr = 0;
            m_e.m2 = 0;
            m_e.wm = 0;
        end else if (!stall) begin
            m_e = nxt;
        end
    endtask

    always @(negedge clock) begin
        if (chk_en) begin
            chk("mdl_mmWreg", {31'b0, mmWreg}, {31'b0, m_e.v & m_e.wr});
            chk("mdl_mmM2reg", {31'b0, mmM2reg}, {31'b0, m_e.v & m_e.m2});
            if (m_e.v) begin
                chk("mdl_mmAlu", mmAlu, m_e.alu);
                chk("mdl_mmReg", {27'b0, mmReg}, {27'b0, m_e.r});
            end
            chk("mdl_wbWreg", {31'b0, wbWreg}, {31'b0, m_ww});
            if (m_ww) chk("mdl_wbReg", {27'b0, wbReg}, {27'b0, m_wr});
            if (m_wv && m_wk) chk("mdl_wbData", wbData, m_wd);
            chk("mdl_memFault", {31'b0, memFault}, {31'b0, m_fault});
        end
    end

    task automatic tick();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic set_ex(input bit v, input bit [31:0] alu,
                          input bit [31:0] db, input bit [4:0] r,
                          input bit wr, input bit m2, input bit wm);
        exValid = v;
        exAlu   = alu;
        exDataB = db;
        exReg   = r;
        exWreg  = wr;
        exM2reg = m2;
        exWmem  = wm;
    endtask

    task automatic bubble();
        set_ex(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        total  = 0;
        passed = 0;
        chk_en = 0;
        for (int i = 0; i < 2**AW; i++) begin
            m_mem[i]   = 0;
            m_known[i] = 0;
        end
        reset = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        bubble();
        #1;
        model_reset();
        chk("rst_wbData", wbData, 32'h0);
        chk("rst_wbWreg", {31'b0, wbWreg}, 32'h0);
        chk("rst_mmWreg", {31'b0, mmWreg}, 32'h0);
        chk("rst_memFault", {31'b0, memFault}, 32'h0);
        chk_en = 1;
        tick();
        tick();
        reset = 1'b0;

        // ALU pass-through
        set_ex(1, 32'h1234, 0, 5, 1, 0, 0);
        tick();
        chk("alu_mmAlu", mmAlu, 32'h1234);
        chk("alu_mmWreg", {31'b0, mmWreg}, 32'h1);
        bubble();
        tick();
        chk("alu_wbData", wbData, 32'h1234);
        chk("alu_wbReg", {27'b0, wbReg}, 32'd5);
        chk("alu_wbWreg", {31'b0, wbWreg}, 32'h1);

        // Store then back-to-back load
        set_ex(1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 1);
        tick();
        set_ex(1, 32'h10, 0, 8, 1, 1, 0);
        tick();
        chk("sl_mmM2reg", {31'b0, mmM2reg}, 32'h1);
        bubble();
        tick();
        chk("sl_wbData", wbData, 32'hDEADBEEF);
        chk("sl_wbReg", {27'b0, wbReg}, 32'd8);
        chk("sl_wbWreg", {31'b0, wbWreg}, 32'h1);

        // Aliasing: 0x100 and 0x000 map to word 0
        set_ex(1, 32'h100, 32'hA5A5A5A5, 0, 0, 0, 1);
        tick();
        set_ex(1, 32'h0, 0, 3, 1, 1, 0);
        tick();
        bubble();
        tick();
        chk("alias_wbData", wbData, 32'hA5A5A5A5);
        chk("alias_noFault", {31'b0, memFault}, 32'h0);

        // Misaligned load
        set_ex(1, 32'h12, 0, 4, 1, 1, 0);
        tick();
        bubble();
        tick();
        chk("misld_wbWreg", {31'b0, wbWreg}, 32'h0);
        chk("misld_wbData", wbData, 32'h0);
        chk("misld_fault", {31'b0, memFault}, 32'h1);
        tick();
        chk("misld_fault_held", {31'b0, memFault}, 32'h1);

        // Misaligned store must leave word 0x10 intact
        set_ex(1, 32'h13, 32'h12345678, 0, 0, 0, 1);
        tick();
        set_ex(1, 32'h10, 0, 6, 1, 1, 0);
        tick();
        bubble();
        tick();
        chk("misst_word", wbData, 32'hDEADBEEF);

        // Stall with a store pending
        set_ex(1, 32'h20, 32'h11112222, 0, 0, 0, 1);
        tick();
        set_ex(1, 32'h20, 0, 9, 1, 1, 0);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_mmAlu", mmAlu, 32'h20);
            chk("stall_mmM2reg", {31'b0, mmM2reg}, 32'h0);
        end
        stall = 1'b0;
        tick();
        bubble();
        tick();
        chk("stall_wbData", wbData, 32'h11112222);
        chk("stall_wbReg", {27'b0, wbReg}, 32'd9);

        // Flush while stalled
        set_ex(1, 32'h40, 0, 10, 1, 0, 0);
        tick();
        set_ex(1, 32'h44, 0, 11, 1, 0, 0);
        tick();
        stall = 1'b1;
        flush = 1'b1;
        tick();
        chk("flush_mmWreg", {31'b0, mmWreg}, 32'h0);
        chk("flush_wbData", wbData, 32'h40);
        chk("flush_wbReg", {27'b0, wbReg}, 32'd10);
        chk("flush_wbWreg", {31'b0, wbWreg}, 32'h1);
        stall = 1'b0;
        flush = 1'b0;
        bubble();
        tick();
        chk("flush_bubble_wbWreg", {31'b0, wbWreg}, 32'h0);

        // Reset while a store sits in EX/MEM
        set_ex(1, 32'h30, 32'hCAFEF00D, 0, 0, 0, 1);
        tick();
        bubble();
        tick();
        set_ex(1, 32'h30, 32'h55555555, 0, 0, 0, 1);
        tick();
        bubble();
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        chk("mrst_mmAlu", mmAlu, 32'h0);
        chk("mrst_mmReg", {27'b0, mmReg}, 32'h0);
        chk("mrst_wbData", wbData, 32'h0);
        chk("mrst_wbReg", {27'b0, wbReg}, 32'h0);
        chk("mrst_wbWreg", {31'b0, wbWreg}, 32'h0);
        chk("mrst_memFault", {31'b0, memFault}, 32'h0);
        tick();
        reset = 1'b0;
        set_ex(1, 32'h30, 0, 12, 1, 1, 0);
        tick();
        bubble();
        tick();
        chk("mrst_word_kept", wbData, 32'hCAFEF00D);
        chk("mrst_wbReg12", {27'b0, wbReg}, 32'd12);
        tick();

        chk_en = 0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
